// File: rtl/toggle_handshake_rx.sv
// toggle_handshake_rx
// Two-phase (toggle) handshake receiver. Every level change on req_tgl is one
// transfer event; its payload is captured into a first-word-fall-through FIFO
// and acknowledged by returning ack_tgl at the accepted request level. The
// FIFO head is offered downstream as a valid/ready stream.
//
// Handshake: the downstream consumer takes the head word on any rising edge
// where out_valid and out_ready are both high; out_valid never depends on
// out_ready. Upstream, the producer may toggle req_tgl only when
// ack_tgl == req_tgl, and must hold req_data stable while they differ.
//
// Optional feature: define TOGGLE_RX_SYNC_2FF_EN to pass req_tgl through a
// two-flop synchronizer (two extra cycles of latency, allows an asynchronous
// producer). Without it the producer must be synchronous to clk.

module toggle_handshake_rx #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_tgl,
   input  logic [WIDTH-1:0] req_data,
   output logic             ack_tgl,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [15:0]      event_count,
   output logic             stalled
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   // IDLE: request level already accepted. PENDING: a new level awaits room.
   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } state_e;

   state_e state;
   logic   req_s;

`ifdef TOGGLE_RX_SYNC_2FF_EN
   logic sync1_q;
   logic sync2_q;

   // Two-flop synchronizer on the request level
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= req_tgl;
         sync2_q <= sync1_q;
      end
   end

   assign req_s = sync2_q;
`else
   assign req_s = req_tgl;
`endif

   logic             req_seen_q, req_seen_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [15:0]      event_count_q, event_count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push;
   logic             pop;
   logic             room;
   logic             stalled_d;

   // Event detection, acceptance decision and FIFO bookkeeping
   always_comb begin
      req_seen_d    = req_seen_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      event_count_d = event_count_q;
      push          = 1'b0;
      stalled_d     = 1'b0;

      state = (req_s != req_seen_q) ? ST_PENDING : ST_IDLE;
      pop   = (count_q != '0) && out_ready;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      room  = (count_q < DEPTH_C) || pop;

      case (state)
         ST_IDLE: begin
         end
         ST_PENDING: begin
            if (room) begin
               push          = 1'b1;
               req_seen_d    = req_s;
               event_count_d = event_count_q + 16'd1;
            end else begin
               stalled_d = 1'b1;
            end
         end
         default: begin
         end
      endcase

      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state; reset logically empties the FIFO and drops any pending event
   always_ff @(posedge clk) begin
      if (reset) begin
         req_seen_q    <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         event_count_q <= '0;
      end else begin
         req_seen_q    <= req_seen_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         event_count_q <= event_count_d;
      end
   end

   // FIFO storage; contents need no reset since count gates visibility
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         mem_q[wr_ptr_q] <= req_data;
      end
   end

   assign ack_tgl     = req_seen_q;
   assign out_valid   = (count_q != '0);
   assign out_data    = out_valid ? mem_q[rd_ptr_q] : '0;
   assign event_count = event_count_q;
   assign stalled     = stalled_d;

endmodule

// File: tb/tb_toggle_handshake_rx.sv
// Bench for toggle_handshake_rx: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a queue-based model.

module tb_toggle_handshake_rx;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
`ifdef TOGGLE_RX_SYNC_2FF_EN
   localparam int LAT  = 3;
   localparam bit SYNC = 1'b1;
`else
   localparam int LAT  = 1;
   localparam bit SYNC = 1'b0;
`endif

   logic             clk;
   logic             reset;
   logic             req_tgl;
   logic [WIDTH-1:0] req_data;
   logic             ack_tgl;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic [15:0]      event_count;
   logic             stalled;

   int tests = 0;
   int fails = 0;

   toggle_handshake_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_tgl     (req_tgl),
      .req_data    (req_data),
      .ack_tgl     (ack_tgl),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .event_count (event_count),
      .stalled     (stalled)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a queue of words in flight, the last accepted level and a counter
   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] obs_q[$];
   bit               m_seen;
   bit [15:0]        m_cnt;
   bit               h1, h2;
   bit               model_live = 1'b0;
   bit               collect    = 1'b0;

   function automatic bit m_req_s();
      return SYNC ? h2 : req_tgl;
   endfunction

   always @(posedge clk) begin
      bit rs, pop, push;
      if (reset) begin
         exp_q.delete();
         m_seen     = 1'b0;
         m_cnt      = 16'd0;
         h1         = 1'b0;
         h2         = 1'b0;
         model_live = 1'b1;
      end else if (model_live) begin
         rs   = m_req_s();
         pop  = (exp_q.size() > 0) && out_ready;
         push = (rs != m_seen) && ((exp_q.size() < DEPTH) || pop);
         if (pop) void'(exp_q.pop_front());
         if (push) begin
            exp_q.push_back(req_data);
            m_seen = rs;
            m_cnt  = m_cnt + 16'd1;
         end
         h2 = h1;
         h1 = req_tgl;
      end
   end

   // Compare process, away from the active edge
   always @(negedge clk) begin
      bit pend, room, exp_st;
      if (model_live) begin
         pend   = (m_req_s() != m_seen);
         room   = (exp_q.size() < DEPTH) || (out_ready && exp_q.size() > 0);
         exp_st = pend && !room;
         check("cyc_ack", 32'(ack_tgl), 32'(m_seen));
         check("cyc_valid", 32'(out_valid), 32'(exp_q.size() > 0));
         check("cyc_data", 32'(out_data), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'd0);
         check("cyc_count", 32'(event_count), 32'(m_cnt));
         check("cyc_stalled", 32'(stalled), 32'(exp_st));
         if (collect && out_valid && out_ready) obs_q.push_back(out_data);
      end
   end

   // Driver tasks; inputs change 1 time unit after the rising edge
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req_tgl   = 1'b0;
      out_ready = 1'b0;
      step(2);
      reset = 1'b0;
   endtask

   task automatic wait_ack(input string name);
      int budget = 50;
      while (ack_tgl !== req_tgl && budget > 0) begin
         step(1);
         budget--;
      end
      if (ack_tgl !== req_tgl) begin
         tests++;
         fails++;
         $display("FAIL %s: ack %0b never matched req %0b", name, ack_tgl, req_tgl);
      end
   endtask

   task automatic send_event(input logic [WIDTH-1:0] d);
      req_data = d;
      req_tgl  = ~req_tgl;
   endtask

   initial begin
      int n;
      bit ack_before;
      reset     = 1'b1;
      req_tgl   = 1'b0;
      req_data  = '0;
      out_ready = 1'b0;

      // Reset state and first event
      do_reset();
      check("rst_ack", 32'(ack_tgl), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_count", 32'(event_count), 32'd0);
      check("rst_stalled", 32'(stalled), 32'd0);
      send_event(8'hA5);
      step(LAT);
      check("first_ack", 32'(ack_tgl), 32'd1);
      check("first_valid", 32'(out_valid), 32'd1);
      check("first_data", 32'(out_data), 32'hA5);
      check("first_count", 32'(event_count), 32'd1);

      // Fill and stall
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         send_event(WIDTH'(i));
         wait_ack("fill_ack");
      end
      ack_before = ack_tgl;
      send_event(8'd5);
      step(LAT + 2);
      check("stall_flag", 32'(stalled), 32'd1);
      check("stall_ack_hold", 32'(ack_tgl), 32'(ack_before));
      check("stall_count", 32'(event_count), 32'd4);
      check("stall_head", 32'(out_data), 32'd1);
      out_ready = 1'b1;
      step(1);
      out_ready = 1'b0;
      check("unstall_flag", 32'(stalled), 32'd0);
      check("unstall_count", 32'(event_count), 32'd5);
      check("unstall_head", 32'(out_data), 32'd2);
      check("unstall_ack", 32'(ack_tgl), 32'(req_tgl));

      // Order and pointer wrap
      do_reset();
      obs_q.delete();
      collect   = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         send_event(WIDTH'(8'h10 + i));
         wait_ack("order_ack");
      end
      step(4);
      collect = 1'b0;
      check("order_len", 32'(obs_q.size()), 32'd10);
      for (int i = 0; i < 10 && i < obs_q.size(); i++)
         check("order_word", 32'(obs_q[i]), 32'(8'h10 + i));
      check("order_count", 32'(event_count), 32'd10);

      // Simultaneous push and pop at full occupancy
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         send_event(WIDTH'(8'h20 + i));
         wait_ack("full_ack");
      end
      send_event(8'h25);
      out_ready = 1'b1;
      step(1);
      out_ready = 1'b0;
      wait_ack("pp_ack");
      check("pp_head", 32'(out_data), 32'h22);
      check("pp_count", 32'(event_count), 32'd5);
      obs_q.delete();
      collect   = 1'b1;
      out_ready = 1'b1;
      step(6);
      out_ready = 1'b0;
      collect   = 1'b0;
      check("pp_len", 32'(obs_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < obs_q.size(); i++)
         check("pp_word", 32'(obs_q[i]), 32'(8'h22 + i));
      check("pp_empty", 32'(out_valid), 32'd0);

`ifndef TOGGLE_RX_SYNC_2FF_EN
      // Counter wrap: 65535 events back to back, then one more
      do_reset();
      out_ready = 1'b1;
      n = 0;
      for (int it = 0; it < 70000 && n < 65535; it++) begin
         if (ack_tgl == req_tgl) begin
            send_event(WIDTH'($urandom));
            n++;
         end
         step(1);
      end
      wait_ack("wrap_ack");
      check("wrap_ffff", 32'(event_count), 32'hFFFF);
      send_event(8'h3C);
      wait_ack("wrap_ack2");
      check("wrap_zero", 32'(event_count), 32'd0);
`endif

      // Mid-operation reset with an event pending
      do_reset();
      for (int i = 0; i < 3; i++) begin
         send_event(WIDTH'(8'h40 + i));
         wait_ack("mid_ack");
      end
      send_event(8'h77);
      reset = 1'b1;
      step(1);
      reset   = 1'b0;
      req_tgl = 1'b0;
      check("mid_valid", 32'(out_valid), 32'd0);
      check("mid_ack0", 32'(ack_tgl), 32'd0);
      check("mid_count", 32'(event_count), 32'd0);
      req_data = 8'h99;
      req_tgl  = 1'b1;
      step(LAT + 8);
      check("mid_one_count", 32'(event_count), 32'd1);
      check("mid_one_valid", 32'(out_valid), 32'd1);
      check("mid_one_data", 32'(out_data), 32'h99);
      check("mid_one_ack", 32'(ack_tgl), 32'd1);

      // Randomized traffic with random backpressure
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         out_ready = ($urandom_range(0, 99) < 45);
         if (ack_tgl == req_tgl && $urandom_range(0, 1) == 1)
            send_event(WIDTH'($urandom));
         step(1);
      end
      out_ready = 1'b1;
      step(LAT + 8);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/toggle_handshake_rx.md
# toggle_handshake_rx

Two-phase (toggle) handshake receiver that sits directly downstream of a toggle-signalling producer such as the A/B parity-toggle stage. Each level change on `req_tgl` is one transfer event. The block captures `req_data` into a small first-word-fall-through FIFO and returns an `ack_tgl` level matching `req_tgl`. It presents the data to the consumer as a valid/ready stream and counts accepted events.

## Interface
- `WIDTH`, 8, payload width in bits.
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_tgl`  in  1  producer request level; each toggle is one event.
- `req_data`  in  WIDTH  payload; held stable by the producer while `req_tgl != ack_tgl`.
- `ack_tgl`  out  1  acknowledge level; equals the accepted `req_tgl` level.
- `out_valid`  out  1  FIFO non-empty.
- `out_data`  out  WIDTH  head entry; 0 when `out_valid` = 0.
- `out_ready`  in  1  consumer accepts head when high with `out_valid`.
- `event_count`  out  16  accepted events, wraps modulo 2^16.
- `stalled`  out  1  an event is pending but the FIFO is full.

## Operation
- `req_s`: `req_tgl` after the optional synchronizer (see Configuration). `req_seen`: the last accepted level.
- Event: `req_s != req_seen`.
- FSM has 2 states, evaluated every cycle:
  - IDLE (`req_s == req_seen`): no push.
  - PENDING (`req_s != req_seen`): if `room` = (count < DEPTH) OR (pop this cycle), then:
    - push `req_data`;
    - `req_seen <= req_s`;
    - `ack_tgl <= req_s`;
    - `event_count++`.
  - If there is no room, stay PENDING with `stalled` = 1. `ack_tgl` is held and the producer waits.
- Pop: `out_valid & out_ready` advances `rd_ptr`.
- Push and pop in the same cycle are legal at any occupancy, including full; count is unchanged.
- No empty bypass: a pushed word appears on `out_data` the cycle after the push.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Protocol: the producer must not toggle `req_tgl` again until `ack_tgl == req_tgl`. A double toggle within one acceptance window is invisible and is not detected.
- Reset mid-operation clears all of the following:
  - FIFO contents (logically);
  - pending event;
  - `event_count`.

  A producer not reset together with this block must re-align, because a `req_tgl` = 1 after reset is seen as one new event.

## Timing
- Reset values (the cycle after `reset` is sampled high):
  - `ack_tgl` = 0, `req_seen` = 0, synchronizer flops = 0;
  - `out_valid` = 0, `out_data` = 0;
  - `event_count` = 0, `stalled` = 0;
  - pointers and count = 0.
- `reset` has priority over every other input in the same cycle.
- Without the synchronizer, `req_tgl` changes after edge k:
  - push, `ack_tgl` toggle and `event_count` increment happen at edge k+1;
  - `out_valid` = 1 after edge k+1.
- With the synchronizer, the same events happen at edge k+3. `req_data` is sampled at that edge and must still be stable.
- Full FIFO with an event pending: `stalled` is high from the cycle the event is detected. Acceptance occurs on the first edge where `out_ready & out_valid` is true, or where count has dropped below DEPTH.
- Throughput: one event per cycle maximum without the synchronizer. The producer's round-trip limits the practical rate.

## Configuration
- `TOGGLE_RX_SYNC_2FF_EN`:
  - Defined: `req_tgl` passes through two `clk` flops before event detection. This adds 2 cycles of latency and allows an asynchronous producer.
  - Undefined: `req_s = req_tgl` directly, and the producer must be synchronous to `clk`.
- Both builds share identical FIFO, counter and reset behaviour.

## Test plan
- Reset: hold `reset` 2 cycles with `req_tgl` = 0. Required: all outputs 0. Then toggle `req_tgl` to 1 with `req_data` = 8'hA5. Required: after 1 cycle (3 with the macro) `ack_tgl` = 1, `out_valid` = 1, `out_data` = 8'hA5, `event_count` = 1.
- Fill and stall: `out_ready` = 0, send 5 events with data 1..5, each sent only after its ack. Required: events 1–4 acked. On event 5, `stalled` = 1 and `ack_tgl` holds. Raise `out_ready` for 1 cycle. Required: head = 1 is popped, 5 is accepted at the same edge, `stalled` = 0, `event_count` = 5.
- Order and wrap: 10 events with data 0x10..0x19 and `out_ready` = 1 throughout. Required: output order 0x10..0x19, pointers wrap past DEPTH, no loss.
- Simultaneous push/pop at full occupancy (4 entries): event and pop in the same cycle. Required: count stays 4, new data lands at the tail.
- Counter wrap: preload by 65535 accepted events, then send 1 more. Required: `event_count` = 0.
- Mid-operation reset: 3 entries queued and an event pending. Assert `reset` for 1 cycle. Required: `out_valid` = 0, `ack_tgl` = 0, `event_count` = 0. Next, `req_tgl` = 1 held. Required: exactly one event is accepted.
